// File: rtl/tcp_sched_flag_table.sv
// Per-flow pending-flag table (retransmit / ack / data) with a round-robin scheduler
// that hands {flowid, flags} records to the packet builder. Optional macro: SCHED_RT_PRIORITY_EN.
module tcp_sched_flag_table #(
    parameter int FLOWID_W            = 3,
    parameter int SCHED_CMD_STRUCT_W  = FLOWID_W + 6,
    parameter int SCHED_DATA_STRUCT_W = FLOWID_W + 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_sched_cmd_val,
    input  logic [SCHED_CMD_STRUCT_W-1:0]  src_sched_cmd,
    output logic                           sched_src_cmd_rdy,
    output logic                           sched_dst_data_val,
    output logic [SCHED_DATA_STRUCT_W-1:0] sched_dst_data,
    input  logic                           dst_sched_data_rdy
);

    localparam int NUM_FLOWS = 2 ** FLOWID_W;

    typedef enum logic {
        SCAN,
        OUTPUT
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [NUM_FLOWS-1:0]           rt_flags;
    logic [NUM_FLOWS-1:0]           ack_flags;
    logic [NUM_FLOWS-1:0]           data_flags;
    logic [NUM_FLOWS-1:0]           rt_next;
    logic [NUM_FLOWS-1:0]           ack_next;
    logic [NUM_FLOWS-1:0]           data_next;
    logic [NUM_FLOWS-1:0]           pend;
    logic [FLOWID_W-1:0]            rr_ptr;
    logic [SCHED_DATA_STRUCT_W-1:0] record;

    logic [FLOWID_W-1:0]            cmd_flow;
    logic [1:0]                     rt_cmd;
    logic [1:0]                     ack_cmd;
    logic [1:0]                     data_cmd;
    logic                           cmd_fire;

    logic [FLOWID_W-1:0]            held_flow;
    logic                           held_rt;
    logic                           held_ack;
    logic                           held_data;
    logic                           deq;

    logic [FLOWID_W:0]              pick;
    logic                           pick_found;
    logic [FLOWID_W-1:0]            pick_flow;

    // Returns {found, index} of the first set request at or after ptr, wrapping.
    function automatic logic [FLOWID_W:0] rr_pick(input logic [NUM_FLOWS-1:0] req,
                                                  input logic [FLOWID_W-1:0]  ptr);
        logic                found;
        logic [FLOWID_W-1:0] win;
        logic [FLOWID_W-1:0] idx;
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < NUM_FLOWS; k++) begin
            idx = ptr + FLOWID_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    function automatic logic apply_cmd(input logic cur, input logic [1:0] c);
        logic nxt;
        case (c)
            2'd0:    nxt = 1'b1;
            2'd1:    nxt = 1'b0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign cmd_flow = src_sched_cmd[SCHED_CMD_STRUCT_W-1 -: FLOWID_W];
    assign rt_cmd   = src_sched_cmd[5:4];
    assign ack_cmd  = src_sched_cmd[3:2];
    assign data_cmd = src_sched_cmd[1:0];
    assign cmd_fire = src_sched_cmd_val & ~rst;

    assign held_flow = record[SCHED_DATA_STRUCT_W-1 -: FLOWID_W];
    assign held_rt   = record[2];
    assign held_ack  = record[1];
    assign held_data = record[0];
    assign deq       = (state == OUTPUT) & dst_sched_data_rdy;

    assign pend = rt_flags | ack_flags | data_flags;

`ifdef SCHED_RT_PRIORITY_EN
    logic [FLOWID_W:0] rt_pick;
    logic [FLOWID_W:0] pend_pick;
    assign rt_pick   = rr_pick(rt_flags, rr_ptr);
    assign pend_pick = rr_pick(pend, rr_ptr);
    assign pick      = rt_pick[FLOWID_W] ? rt_pick : pend_pick;
`else
    assign pick = rr_pick(pend, rr_ptr);
`endif

    assign pick_found = pick[FLOWID_W];
    assign pick_flow  = pick[FLOWID_W-1:0];

    // Dequeue clears only the flags it reported; a same-cycle command is applied after, so it wins.
    always_comb begin
        rt_next   = rt_flags;
        ack_next  = ack_flags;
        data_next = data_flags;
        if (deq) begin
            if (held_rt)   rt_next[held_flow]   = 1'b0;
            if (held_ack)  ack_next[held_flow]  = 1'b0;
            if (held_data) data_next[held_flow] = 1'b0;
        end
        if (cmd_fire) begin
            rt_next[cmd_flow]   = apply_cmd(rt_next[cmd_flow], rt_cmd);
            ack_next[cmd_flow]  = apply_cmd(ack_next[cmd_flow], ack_cmd);
            data_next[cmd_flow] = apply_cmd(data_next[cmd_flow], data_cmd);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SCAN:    if (pick_found) state_next = OUTPUT;
            OUTPUT:  if (dst_sched_data_rdy) state_next = SCAN;
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SCAN;
            rt_flags   <= '0;
            ack_flags  <= '0;
            data_flags <= '0;
            rr_ptr     <= '0;
            record     <= '0;
        end else begin
            state      <= state_next;
            rt_flags   <= rt_next;
            ack_flags  <= ack_next;
            data_flags <= data_next;
            if (state == SCAN && pick_found)
                record <= {pick_flow, rt_flags[pick_flow], ack_flags[pick_flow], data_flags[pick_flow]};
            if (deq)
                rr_ptr <= held_flow + FLOWID_W'(1);
        end
    end

    assign sched_src_cmd_rdy  = ~rst;
    assign sched_dst_data_val = (state == OUTPUT);
    assign sched_dst_data     = record;

endmodule

// File: tb/tb_tcp_sched_flag_table.sv
// Directed bench for tcp_sched_flag_table: expected records go into a queue that a
// negedge monitor drains on every handshake; timing and hold behaviour are checked inline.
module tb_tcp_sched_flag_table;

    localparam int FLOWID_W = 3;
    localparam int CMD_W    = FLOWID_W + 6;
    localparam int DATA_W   = FLOWID_W + 3;

    localparam logic [1:0] SET = 2'd0;
    localparam logic [1:0] CLR = 2'd1;
    localparam logic [1:0] NOP = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic              src_sched_cmd_val;
    logic [CMD_W-1:0]  src_sched_cmd;
    logic              sched_src_cmd_rdy;
    logic              sched_dst_data_val;
    logic [DATA_W-1:0] sched_dst_data;
    logic              dst_sched_data_rdy;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mon_exp;
    int                assert_count = 0;
    int                fail_count   = 0;

    always #5 clk = ~clk;

    tcp_sched_flag_table #(
        .FLOWID_W           (FLOWID_W),
        .SCHED_CMD_STRUCT_W (CMD_W),
        .SCHED_DATA_STRUCT_W(DATA_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .src_sched_cmd_val (src_sched_cmd_val),
        .src_sched_cmd     (src_sched_cmd),
        .sched_src_cmd_rdy (sched_src_cmd_rdy),
        .sched_dst_data_val(sched_dst_data_val),
        .sched_dst_data    (sched_dst_data),
        .dst_sched_data_rdy(dst_sched_data_rdy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [FLOWID_W-1:0] flow,
                                 input logic [1:0] rtc, input logic [1:0] ackc, input logic [1:0] datac);
        src_sched_cmd_val = v;
        src_sched_cmd     = {flow, rtc, ackc, datac};
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, NOP, NOP, NOP);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rec(input int flow, input bit r, input bit a, input bit d);
        return {FLOWID_W'(flow), r, a, d};
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every accepted record must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && sched_dst_data_val && dst_sched_data_rdy) begin
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL unexpected_record: got 0x%0h, expected none at %0t", sched_dst_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("record", 32'(sched_dst_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        fail_count++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        bit exp_v [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        dst_sched_data_rdy = 1'b1;
        idle();

        // Reset and idle
        step();
        step();
        @(negedge clk);
        checkOutput("rst_cmd_rdy", 32'(sched_src_cmd_rdy), 32'd0);
        checkOutput("rst_val", 32'(sched_dst_data_val), 32'd0);
        checkOutput("rst_data", 32'(sched_dst_data), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle_val", 32'(sched_dst_data_val), 32'd0);
            checkOutput("idle_cmd_rdy", 32'(sched_src_cmd_rdy), 32'd1);
            step();
        end

        // Single data SET on flow 5: val two cycles after the command
        applyStimulus(1'b1, 3'd5, NOP, NOP, SET);
        exp_q.push_back(rec(5, 0, 0, 1));
        @(negedge clk);
        checkOutput("lat_val_t0", 32'(sched_dst_data_val), 32'd0);
        step();
        idle();
        @(negedge clk);
        checkOutput("lat_val_t1", 32'(sched_dst_data_val), 32'd0);
        step();
        @(negedge clk);
        checkOutput("lat_val_t2", 32'(sched_dst_data_val), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            checkOutput("after_deq_val", 32'(sched_dst_data_val), 32'd0);
        end

        // Reset to bring rr_ptr back to 0, then burst on flows 1, 3, 6
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.push_back(rec(1, 0, 0, 1));
        exp_q.push_back(rec(3, 0, 0, 1));
        exp_q.push_back(rec(6, 0, 0, 1));
        for (int c = 0; c < 7; c++) begin
            if (c > 0) step();
            case (c)
                0:       applyStimulus(1'b1, 3'd1, NOP, NOP, SET);
                1:       applyStimulus(1'b1, 3'd3, NOP, NOP, SET);
                2:       applyStimulus(1'b1, 3'd6, NOP, NOP, SET);
                default: idle();
            endcase
            @(negedge clk);
            checkOutput("burst_val", 32'(sched_dst_data_val), 32'(exp_v[c]));
        end
        step();
        @(negedge clk);
        checkOutput("burst_end_val", 32'(sched_dst_data_val), 32'd0);
        drain("burst_drain");

        // Flow 1 again: found after the scan wraps from rr_ptr=7
        step();
        applyStimulus(1'b1, 3'd1, NOP, NOP, SET);
        exp_q.push_back(rec(1, 0, 0, 1));
        step();
        idle();
        drain("wrap_drain");

        // Flow 2 held with rdy=0; a CLEAR while held does not alter the record
        step();
        step();
        dst_sched_data_rdy = 1'b0;
        applyStimulus(1'b1, 3'd2, SET, SET, NOP);
        exp_q.push_back(rec(2, 1, 1, 0));
        step();
        idle();
        step();
        for (int h = 0; h < 5; h++) begin
            if (h > 0) step();
            if (h == 1) applyStimulus(1'b1, 3'd2, NOP, CLR, NOP);
            else idle();
            @(negedge clk);
            checkOutput("hold_val", 32'(sched_dst_data_val), 32'd1);
            checkOutput("hold_data", 32'(sched_dst_data), 32'(rec(2, 1, 1, 0)));
        end
        step();
        dst_sched_data_rdy = 1'b1;
        applyStimulus(1'b1, 3'd2, SET, CLR, NOP);
        exp_q.push_back(rec(2, 1, 0, 0));
        step();
        idle();
        drain("collide_drain");

        // Flow 4 held, then reset drops it
        step();
        step();
        dst_sched_data_rdy = 1'b0;
        applyStimulus(1'b1, 3'd4, NOP, NOP, SET);
        step();
        idle();
        step();
        @(negedge clk);
        checkOutput("f4_val", 32'(sched_dst_data_val), 32'd1);
        checkOutput("f4_data", 32'(sched_dst_data), 32'(rec(4, 0, 0, 1)));
        step();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_cmd_rdy", 32'(sched_src_cmd_rdy), 32'd0);
        step();
        rst = 1'b0;
        dst_sched_data_rdy = 1'b1;
        @(negedge clk);
        checkOutput("postrst_val", 32'(sched_dst_data_val), 32'd0);
        checkOutput("postrst_data", 32'(sched_dst_data), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            checkOutput("postrst_idle_val", 32'(sched_dst_data_val), 32'd0);
        end

        // Flow 7 blocks the scan while flow 0 data and flow 7 rt accumulate; rr_ptr returns to 0
        step();
        dst_sched_data_rdy = 1'b0;
        applyStimulus(1'b1, 3'd7, NOP, NOP, SET);
        exp_q.push_back(rec(7, 0, 0, 1));
`ifdef SCHED_RT_PRIORITY_EN
        exp_q.push_back(rec(7, 1, 0, 0));
        exp_q.push_back(rec(0, 0, 0, 1));
`else
        exp_q.push_back(rec(0, 0, 0, 1));
        exp_q.push_back(rec(7, 1, 0, 0));
`endif
        step();
        idle();
        step();
        applyStimulus(1'b1, 3'd0, NOP, NOP, SET);
        @(negedge clk);
        checkOutput("blk_val", 32'(sched_dst_data_val), 32'd1);
        step();
        applyStimulus(1'b1, 3'd7, SET, NOP, NOP);
        step();
        idle();
        step();
        dst_sched_data_rdy = 1'b1;
        drain("prio_drain");

        for (int i = 0; i < 4; i++) step();
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("final_val", 32'(sched_dst_data_val), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
